// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the 32-bit ALU and the clients that borrow it.
//   - DATA_W         : default datapath width (32)
//   - alu_op_e       : ALUOperation encodings understood by the shared ALU
//   - seq_state_e    : state encoding of the multiply sequencer
//   - unsigned_lt    : unsigned less-than helper, used for carry detection
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_NOR = 4'b0010,
        ALU_ADD = 4'b0011,
        ALU_SUB = 4'b0100,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b1001,
        ALU_MEM = 4'b1010,
        ALU_JR  = 4'b1011,
        ALU_BEQ = 4'b1100,
        ALU_LUI = 4'b1110
    } alu_op_e;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_ITER = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

    // A wrap-around ADD produced a carry exactly when the sum is smaller than
    // the value it started from.
    function automatic logic unsigned_lt(input logic [DATA_W-1:0] lhs,
                                         input logic [DATA_W-1:0] rhs);
        return lhs < rhs;
    endfunction

endpackage

// File: rtl/alu_mult_sequencer.sv
// ---------------------------------------------------------------------------
// alu_mult_sequencer
// Multi-cycle 32x32 unsigned multiply (low word) for the MIPS mul path.
// Shift-and-add: each ITER cycle issues one ADD to the shared ALU
// (acc + shifted multiplicand); the shifts live in local registers.
// The sequencer owns the ALU inputs only while alu_sel is high (ITER).
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-high reset
//   start             multiply request, sampled only in IDLE
//   op_a, op_b        multiplicand / multiplier, captured on accept
//   busy              high in ITER and DONE (stalls the datapath)
//   done              one-cycle pulse, result/ovf valid
//   result, ovf       low product word and "product >= 2^32", held
//   alu_sel           1 = sequencer drives the ALU input mux
//   alu_op            constant ADD
//   alu_a, alu_b      accumulator / shifted multiplicand
//   alu_shamt         constant 0
//   alu_result        combinational ALU result for alu_a + alu_b
// ---------------------------------------------------------------------------
module alu_mult_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W     = alu_pkg::DATA_W,
    parameter int CNT_W      = 6,
    parameter int EARLY_EXIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              ovf,
    output logic              alu_sel,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_shamt,
    input  logic [DATA_W-1:0] alu_result
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    seq_state_e        state_q,    state_d;
    logic [DATA_W-1:0] acc_q,      acc_d;
    logic [DATA_W-1:0] mcand_q,    mcand_d;
    logic [DATA_W-1:0] mplier_q,   mplier_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              ovf_acc_q,  ovf_acc_d;
    logic [DATA_W-1:0] result_q,   result_d;
    logic              ovf_q,      ovf_d;

    logic [DATA_W-1:0] mplier_shr;
    logic              last_iter;

    assign mplier_shr = mplier_q >> 1;

    // Finish after the last bit position, or early once no multiplier bits
    // remain (further ADDs would only add zero).
    assign last_iter = (cnt_q == LAST_CNT) ||
                       ((EARLY_EXIT != 0) && (mplier_shr == '0));

    // ---- state / datapath registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SEQ_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        result_d  = result_q;
        ovf_d     = ovf_q;

        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    acc_d     = '0;
                    mcand_d   = op_a;
                    mplier_d  = op_b;
                    cnt_d     = '0;
                    ovf_acc_d = 1'b0;
                    state_d   = SEQ_ITER;
                end
            end

            SEQ_ITER: begin
                if (mplier_q[0]) begin
                    acc_d = alu_result;
                    if (unsigned_lt(alu_result, acc_q)) begin
                        ovf_acc_d = 1'b1;
                    end
                end
                // The multiplicand MSB is about to be shifted out; if any
                // multiplier bit is still pending it would have contributed
                // at weight >= 2^32, so the full product overflows.
                if (mcand_q[DATA_W-1] && (mplier_shr != '0)) begin
                    ovf_acc_d = 1'b1;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shr;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    // Capture on DONE entry so result/ovf are visible
                    // together with the done pulse.
                    result_d = acc_d;
                    ovf_d    = ovf_acc_d;
                    state_d  = SEQ_DONE;
                end
            end

            SEQ_DONE: begin
                state_d = SEQ_IDLE;
            end

            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    // ---- outputs ----
    assign busy      = (state_q == SEQ_ITER) || (state_q == SEQ_DONE);
    assign done      = (state_q == SEQ_DONE);
    assign alu_sel   = (state_q == SEQ_ITER);
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign alu_op    = ALU_ADD;
    assign alu_a     = acc_q;
    assign alu_b     = mcand_q;
    assign alu_shamt = 5'd0;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
module tb_alu_mult_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DUT 0: EARLY_EXIT = 1
    logic        start0;
    logic [31:0] a0, b0;
    logic        busy0, done0, ovf0, alu_sel0;
    logic [31:0] result0, alu_a0, alu_b0, alu_res0;
    logic [3:0]  alu_op0;
    logic [4:0]  alu_shamt0;

    // DUT 1: EARLY_EXIT = 0
    logic        start1;
    logic [31:0] a1, b1;
    logic        busy1, done1, ovf1, alu_sel1;
    logic [31:0] result1, alu_a1, alu_b1, alu_res1;
    logic [3:0]  alu_op1;
    logic [4:0]  alu_shamt1;

    // Shared-ALU stand-in: only ADD matters to the sequencer.
    assign alu_res0 = (alu_op0 == 4'b0011) ? alu_a0 + alu_b0 : 32'h0;
    assign alu_res1 = (alu_op1 == 4'b0011) ? alu_a1 + alu_b1 : 32'h0;

    alu_mult_sequencer #(.DATA_W(32), .CNT_W(6), .EARLY_EXIT(1)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .op_a(a0), .op_b(b0),
        .busy(busy0), .done(done0), .result(result0), .ovf(ovf0),
        .alu_sel(alu_sel0), .alu_op(alu_op0), .alu_a(alu_a0), .alu_b(alu_b0),
        .alu_shamt(alu_shamt0), .alu_result(alu_res0)
    );

    alu_mult_sequencer #(.DATA_W(32), .CNT_W(6), .EARLY_EXIT(0)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .op_a(a1), .op_b(b1),
        .busy(busy1), .done(done1), .result(result1), .ovf(ovf1),
        .alu_sel(alu_sel1), .alu_op(alu_op1), .alu_a(alu_a1), .alu_b(alu_b1),
        .alu_shamt(alu_shamt1), .alu_result(alu_res1)
    );

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a multiply on DUT 0 from IDLE and run until done (bounded).
    // Returns in the done cycle; cycles are numbered from the accept edge.
    task automatic run0(input logic [31:0] a, input logic [31:0] b,
                        output int done_cyc, output int sel_cnt,
                        output logic [31:0] res, output logic ov);
        start0 = 1'b1; a0 = a; b0 = b;
        tick();
        start0 = 1'b0;
        done_cyc = -1; sel_cnt = 0; res = 32'h0; ov = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (alu_sel0) sel_cnt++;
            if (done0) begin
                done_cyc = c; res = result0; ov = ovf0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done0); end
        checks++; if (alu_sel0 !== 1'b0) begin errors++; $display("FAIL reset_alu_sel got %b want 0", alu_sel0); end
        checks++; if (result0 !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", result0); end
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf0); end
        checks++; if (alu_op0 !== 4'b0011) begin errors++; $display("FAIL alu_op got %b want 0011", alu_op0); end
        checks++; if (alu_shamt0 !== 5'd0) begin errors++; $display("FAIL alu_shamt got %0d want 0", alu_shamt0); end
    endtask

    task automatic test_basic();
        int dc, sc; logic [31:0] r; logic o;
        run0(32'd7, 32'd6, dc, sc, r, o);
        checks++; if (dc !== 4) begin errors++; $display("FAIL basic_done_cycle got %0d want 4", dc); end
        checks++; if (sc !== 3) begin errors++; $display("FAIL basic_sel_cycles got %0d want 3", sc); end
        checks++; if (r !== 32'd42) begin errors++; $display("FAIL basic_result got %0d want 42", r); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", o); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy_done got %b want 1", busy0); end
        tick();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done0); end
        checks++; if (result0 !== 32'd42) begin errors++; $display("FAIL basic_result_hold got %0d want 42", result0); end
    endtask

    task automatic test_reset_midop();
        int pulses = 0;
        start0 = 1'b1; a0 = 32'hFFFFFFFF; b0 = 32'hFFFFFFFF;
        tick();
        start0 = 1'b0;
        tick(); tick(); tick();
        checks++; if (alu_sel0 !== 1'b1) begin errors++; $display("FAIL midop_in_iter got %b want 1", alu_sel0); end
        reset = 1'b1;
        tick();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midop_busy got %b want 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL midop_done got %b want 0", done0); end
        checks++; if (alu_sel0 !== 1'b0) begin errors++; $display("FAIL midop_alu_sel got %b want 0", alu_sel0); end
        checks++; if (result0 !== 32'h0) begin errors++; $display("FAIL midop_result got %h want 00000000", result0); end
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL midop_ovf got %b want 0", ovf0); end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done0 || busy0) pulses++;
            tick();
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midop_no_done got %0d active cycles want 0", pulses); end
    endtask

    task automatic test_zero_mplier();
        int dc, sc; logic [31:0] r; logic o;
        run0(32'h12345678, 32'h0, dc, sc, r, o);
        checks++; if (dc !== 2) begin errors++; $display("FAIL zero_done_cycle got %0d want 2", dc); end
        checks++; if (sc !== 1) begin errors++; $display("FAIL zero_sel_cycles got %0d want 1", sc); end
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL zero_result got %h want 00000000", r); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL zero_ovf got %b want 0", o); end
        tick();
    endtask

    task automatic test_full_width();
        int dc, sc; logic [31:0] r; logic o;
        run0(32'hFFFFFFFF, 32'hFFFFFFFF, dc, sc, r, o);
        checks++; if (dc !== 33) begin errors++; $display("FAIL full_done_cycle got %0d want 33", dc); end
        checks++; if (sc !== 32) begin errors++; $display("FAIL full_sel_cycles got %0d want 32", sc); end
        checks++; if (r !== 32'h00000001) begin errors++; $display("FAIL full_result got %h want 00000001", r); end
        checks++; if (o !== 1'b1) begin errors++; $display("FAIL full_ovf got %b want 1", o); end
        tick();
    endtask

    task automatic test_no_early_exit();
        int dc = -1;
        start1 = 1'b1; a1 = 32'hDEADBEEF; b1 = 32'h1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (done1) begin dc = c; break; end
            tick();
        end
        checks++; if (dc !== 33) begin errors++; $display("FAIL noearly_done_cycle got %0d want 33", dc); end
        checks++; if (result1 !== 32'hDEADBEEF) begin errors++; $display("FAIL noearly_result got %h want deadbeef", result1); end
        checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL noearly_ovf got %b want 0", ovf1); end
        tick();
    endtask

    task automatic test_overflow_edges();
        int dc, sc; logic [31:0] r; logic o;
        run0(32'h00010000, 32'h00010000, dc, sc, r, o);
        checks++; if (sc !== 17) begin errors++; $display("FAIL pow_sel_cycles got %0d want 17", sc); end
        checks++; if (dc !== 18) begin errors++; $display("FAIL pow_done_cycle got %0d want 18", dc); end
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL pow_result got %h want 00000000", r); end
        checks++; if (o !== 1'b1) begin errors++; $display("FAIL pow_ovf got %b want 1", o); end
        tick();
        run0(32'h0000FFFF, 32'h00010001, dc, sc, r, o);
        checks++; if (sc !== 17) begin errors++; $display("FAIL fit_sel_cycles got %0d want 17", sc); end
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL fit_result got %h want ffffffff", r); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL fit_ovf got %b want 0", o); end
        tick();
    endtask

    task automatic test_back_to_back();
        int dc = -1;
        start0 = 1'b1; a0 = 32'd7; b0 = 32'd6;
        tick();                                   // cycle 1 (ITER)
        start0 = 1'b0;
        tick();                                   // cycle 2 (ITER)
        start0 = 1'b1; a0 = 32'd100; b0 = 32'd200;
        tick();                                   // cycle 3 (ITER)
        start0 = 1'b0;
        tick();                                   // cycle 4 (DONE)
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", done0); end
        checks++; if (result0 !== 32'd42) begin errors++; $display("FAIL b2b_first_result got %0d want 42", result0); end
        start0 = 1'b1; a0 = 32'd3; b0 = 32'd3;
        tick();                                   // cycle 5 (IDLE)
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_done_start_ignored got busy %b want 0", busy0); end
        checks++; if (result0 !== 32'd42) begin errors++; $display("FAIL b2b_result_held got %0d want 42", result0); end
        a0 = 32'd9; b0 = 32'd5;
        tick();                                   // accepted; new cycle 1
        start0 = 1'b0; a0 = 32'd1; b0 = 32'hFF;
        for (int c = 1; c <= 10; c++) begin
            if (done0) begin dc = c; break; end
            tick();
        end
        checks++; if (dc !== 4) begin errors++; $display("FAIL b2b_second_done_cycle got %0d want 4", dc); end
        checks++; if (result0 !== 32'd45) begin errors++; $display("FAIL b2b_second_result got %0d want 45", result0); end
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL b2b_second_ovf got %b want 0", ovf0); end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        start0 = 1'b0; a0 = 32'h0; b0 = 32'h0;
        start1 = 1'b0; a1 = 32'h0; b1 = 32'h0;
        test_reset();
        test_basic();
        test_reset_midop();
        test_zero_mplier();
        test_full_width();
        test_no_early_exit();
        test_overflow_edges();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
